// File: rtl/pc_redirect_ctrl.sv
// IF-stage PC-select sequencer: arbitrates redirect requests into a held pc_set,
// pulses a one-hot grant on fetch accept, then blanks redirects for a flush window.
module pc_redirect_ctrl #(
    parameter int FlushCycles = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fetch_ready_i,
    input  logic       jump_req_i,
    input  logic       exc_req_i,
    input  logic [6:0] exc_cause_i,
    input  logic       irq_req_i,
    input  logic [6:0] irq_cause_i,
    input  logic       irq_enable_i,
    input  logic       debug_req_i,
    input  logic       mret_req_i,
    input  logic       dret_req_i,
    output logic       pc_set_o,
    output logic [2:0] pc_mux_o,
    output logic [1:0] exc_pc_mux_o,
    output logic [6:0] exc_cause_o,
    output logic [5:0] grant_o,
    output logic       flush_o,
    output logic       debug_mode_o
);

    localparam int CntW = $clog2(FlushCycles + 1);

    localparam logic [2:0] PC_BOOT = 3'd0;
    localparam logic [2:0] PC_JUMP = 3'd1;
    localparam logic [2:0] PC_EXC  = 3'd2;
    localparam logic [2:0] PC_ERET = 3'd3;
    localparam logic [2:0] PC_DRET = 3'd4;

    localparam logic [1:0] EXC_PC_EXC     = 2'd0;
    localparam logic [1:0] EXC_PC_IRQ     = 2'd1;
    localparam logic [1:0] EXC_PC_DBD     = 2'd2;
    localparam logic [1:0] EXC_PC_DBG_EXC = 2'd3;

    // Grant bit positions: {dret,mret,jump,irq,exc,dbg}
    localparam logic [5:0] G_DBG  = 6'b000001;
    localparam logic [5:0] G_EXC  = 6'b000010;
    localparam logic [5:0] G_IRQ  = 6'b000100;
    localparam logic [5:0] G_JUMP = 6'b001000;
    localparam logic [5:0] G_MRET = 6'b010000;
    localparam logic [5:0] G_DRET = 6'b100000;

    typedef enum logic [2:0] {
        S_RESET,
        S_BOOT,
        S_RUN,
        S_HOLD,
        S_FLUSH
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [5:0]      held_q;
    logic            pc_set_q;
    logic [2:0]      pc_mux_q;
    logic [1:0]      exc_pc_mux_q;
    logic [6:0]      exc_cause_q;
    logic [5:0]      grant_q;
    logic            flush_q;
    logic            debug_mode_q;

    logic [5:0] arb_grant_d;
    logic [2:0] arb_pc_d;
    logic       arb_exc_en_d;
    logic [1:0] arb_exc_d;
    logic       arb_cause_en_d;
    logic [6:0] arb_cause_d;

    // Fixed-priority pick among eligible requests; debug mode gates dbg/irq/dret.
    always_comb begin
        arb_grant_d    = '0;
        arb_pc_d       = pc_mux_q;
        arb_exc_en_d   = 1'b0;
        arb_exc_d      = exc_pc_mux_q;
        arb_cause_en_d = 1'b0;
        arb_cause_d    = exc_cause_q;
        if (debug_req_i && !debug_mode_q) begin
            arb_grant_d  = G_DBG;
            arb_pc_d     = PC_EXC;
            arb_exc_en_d = 1'b1;
            arb_exc_d    = EXC_PC_DBD;
        end else if (exc_req_i) begin
            arb_grant_d    = G_EXC;
            arb_pc_d       = PC_EXC;
            arb_exc_en_d   = 1'b1;
            arb_exc_d      = debug_mode_q ? EXC_PC_DBG_EXC : EXC_PC_EXC;
            arb_cause_en_d = 1'b1;
            arb_cause_d    = exc_cause_i;
        end else if (irq_req_i && irq_enable_i && !debug_mode_q) begin
            arb_grant_d    = G_IRQ;
            arb_pc_d       = PC_EXC;
            arb_exc_en_d   = 1'b1;
            arb_exc_d      = EXC_PC_IRQ;
            arb_cause_en_d = 1'b1;
            arb_cause_d    = irq_cause_i;
        end else if (dret_req_i && debug_mode_q) begin
            arb_grant_d = G_DRET;
            arb_pc_d    = PC_DRET;
        end else if (mret_req_i) begin
            arb_grant_d = G_MRET;
            arb_pc_d    = PC_ERET;
        end else if (jump_req_i) begin
            arb_grant_d = G_JUMP;
            arb_pc_d    = PC_JUMP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_RESET;
            cnt_q        <= '0;
            held_q       <= '0;
            pc_set_q     <= 1'b0;
            pc_mux_q     <= PC_BOOT;
            exc_pc_mux_q <= EXC_PC_EXC;
            exc_cause_q  <= '0;
            grant_q      <= '0;
            flush_q      <= 1'b0;
            debug_mode_q <= 1'b0;
        end else begin
            grant_q <= '0;
            case (state_q)
                S_RESET: begin
                    state_q  <= S_BOOT;
                    pc_set_q <= 1'b1;
                    pc_mux_q <= PC_BOOT;
                end
                S_BOOT: begin
                    if (fetch_ready_i) begin
                        state_q  <= S_FLUSH;
                        pc_set_q <= 1'b0;
                        flush_q  <= 1'b1;
                        cnt_q    <= CntW'(FlushCycles - 1);
                    end
                end
                S_RUN: begin
                    if (arb_grant_d != '0) begin
                        state_q  <= S_HOLD;
                        held_q   <= arb_grant_d;
                        pc_set_q <= 1'b1;
                        pc_mux_q <= arb_pc_d;
                        if (arb_exc_en_d) exc_pc_mux_q <= arb_exc_d;
                        if (arb_cause_en_d) exc_cause_q <= arb_cause_d;
                    end
                end
                S_HOLD: begin
                    if (fetch_ready_i) begin
                        state_q  <= S_FLUSH;
                        grant_q  <= held_q;
                        pc_set_q <= 1'b0;
                        flush_q  <= 1'b1;
                        cnt_q    <= CntW'(FlushCycles - 1);
                        if (held_q[0]) debug_mode_q <= 1'b1;
                        if (held_q[5]) debug_mode_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= S_RESET;
            endcase
        end
    end

    assign pc_set_o     = pc_set_q;
    assign pc_mux_o     = pc_mux_q;
    assign exc_pc_mux_o = exc_pc_mux_q;
    assign exc_cause_o  = exc_cause_q;
    assign grant_o      = grant_q;
    assign flush_o      = flush_q;
    assign debug_mode_o = debug_mode_q;

endmodule
